// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA raster counters, visible-region decode, delayed
//            active-low syncs and a per-frame tick at start of vertical blank.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       clk_d,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = V_VISIBLE + V_FP + V_SYNC;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
        end
    endgenerate

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    int         h_pos;
    int         v_pos;
    logic       hsync_raw;
    logic       vsync_raw;

    always_ff @(posedge clk_d) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign h_pos      = int'(h_cnt);
    assign v_pos      = int'(v_cnt);
    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign video_on   = !reset && (h_pos < H_VISIBLE) && (v_pos < V_VISIBLE);
    assign frame_tick = !reset && (h_cnt == 10'd0) && (v_pos == V_VISIBLE);

    // Forcing the raw syncs high in reset makes the undelayed build read the
    // decode of count 0, and keeps a mid-sync reset from leaking a low pulse.
    assign hsync_raw  = reset || !((h_pos >= HS_START) && (h_pos < HS_END));
    assign vsync_raw  = reset || !((v_pos >= VS_START) && (v_pos < VS_END));

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync = hsync_raw;
            assign vsync = vsync_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe;
            logic [SYNC_DELAY-1:0] vs_pipe;

            always_ff @(posedge clk_d) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe <= SYNC_DELAY'({hs_pipe, hsync_raw});
                    vs_pipe <= SYNC_DELAY'({vs_pipe, vsync_raw});
                end
            end

            assign hsync = hs_pipe[SYNC_DELAY-1];
            assign vsync = vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed self-checking bench for vga_timing_gen (default and
//            reduced raster geometries, sync delays 0/1/3).
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

    logic clk_d = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_d = ~clk_d;

    // Reduced geometry: H total 15 (sync 10..12), V total 10 (sync lines 7..8)
    localparam int ST_H = 15;
    localparam int ST_V = 10;

    logic [9:0] a_px, a_py, b_px, b_py, s1_px, s1_py, s0_px, s0_py, s3_px, s3_py;
    logic a_vo, a_hs, a_vs, a_ft, b_vo, b_hs, b_vs, b_ft;
    logic s1_vo, s1_hs, s1_vs, s1_ft, s0_vo, s0_hs, s0_vs, s0_ft;
    logic s3_vo, s3_hs, s3_vs, s3_ft;

    vga_timing_gen #(.SYNC_DELAY(1)) u_def1 (
        .clk_d(clk_d), .reset(reset), .pixel_x(a_px), .pixel_y(a_py),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft));

    vga_timing_gen #(.SYNC_DELAY(0)) u_def0 (
        .clk_d(clk_d), .reset(reset), .pixel_x(b_px), .pixel_y(b_py),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft));

    vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_DELAY(1)) u_sm1 (
        .clk_d(clk_d), .reset(reset), .pixel_x(s1_px), .pixel_y(s1_py),
        .video_on(s1_vo), .hsync(s1_hs), .vsync(s1_vs), .frame_tick(s1_ft));

    vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_DELAY(0)) u_sm0 (
        .clk_d(clk_d), .reset(reset), .pixel_x(s0_px), .pixel_y(s0_py),
        .video_on(s0_vo), .hsync(s0_hs), .vsync(s0_vs), .frame_tick(s0_ft));

    vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .SYNC_DELAY(3)) u_sm3 (
        .clk_d(clk_d), .reset(reset), .pixel_x(s3_px), .pixel_y(s3_py),
        .video_on(s3_vo), .hsync(s3_hs), .vsync(s3_vs), .frame_tick(s3_ft));

    // Expected sync levels, c cycles after reset release, for delay d
    function automatic logic exp_hs_def(int c, int d);
        int h;
        if (c < d) return 1'b1;
        h = (c - d) % 800;
        return !(h >= 656 && h < 752);
    endfunction

    function automatic logic exp_hs_sm(int c, int d);
        int h;
        if (c < d) return 1'b1;
        h = (c - d) % ST_H;
        return !(h >= 10 && h < 13);
    endfunction

    function automatic logic exp_vs_sm(int c, int d);
        int v;
        if (c < d) return 1'b1;
        v = ((c - d) / ST_H) % ST_V;
        return !(v >= 7 && v < 9);
    endfunction

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (a_px !== 10'd0 || a_py !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", a_px, a_py);
        end
        n_checks++;
        if (a_vo !== 1'b0 || a_ft !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vo_ft got=%0b/%0b exp=0/0", a_vo, a_ft);
        end
        n_checks++;
        if (a_hs !== 1'b1 || a_vs !== 1'b1 || b_hs !== 1'b1 || b_vs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_syncs got=%0b%0b%0b%0b exp=1111", a_hs, a_vs, b_hs, b_vs);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (a_px !== 10'd0 || a_py !== 10'd0 || a_vo !== 1'b1) begin
            n_fail++;
            $display("FAIL release_first got=%0d/%0d vo=%0b exp=0/0 vo=1", a_px, a_py, a_vo);
        end
    endtask

    task automatic test_line();
        for (int c = 1; c <= 800; c++) begin
            tick();
            if (c == 639) begin
                n_checks++;
                if (a_vo !== 1'b1) begin
                    n_fail++;
                    $display("FAIL vo_639 got=%0b exp=1", a_vo);
                end
            end
            if (c == 640) begin
                n_checks++;
                if (a_vo !== 1'b0 || a_px !== 10'd640) begin
                    n_fail++;
                    $display("FAIL vo_640 got=%0b px=%0d exp=0 px=640", a_vo, a_px);
                end
            end
            if (c == 799) begin
                n_checks++;
                if (a_px !== 10'd799 || a_py !== 10'd0) begin
                    n_fail++;
                    $display("FAIL line_end got=%0d/%0d exp=799/0", a_px, a_py);
                end
            end
            if (c == 800) begin
                n_checks++;
                if (a_px !== 10'd0 || a_py !== 10'd1) begin
                    n_fail++;
                    $display("FAIL line_wrap got=%0d/%0d exp=0/1", a_px, a_py);
                end
            end
        end
    endtask

    task automatic test_hsync_default();
        int lows  = 0;
        int first = -1;
        do_reset();
        for (int c = 0; c <= 1700; c++) begin
            n_checks++;
            if (a_hs !== exp_hs_def(c, 1)) begin
                n_fail++;
                $display("FAIL hsync_d1 cyc=%0d got=%0b exp=%0b", c, a_hs, exp_hs_def(c, 1));
            end
            n_checks++;
            if (b_hs !== exp_hs_def(c, 0)) begin
                n_fail++;
                $display("FAIL hsync_d0 cyc=%0d got=%0b exp=%0b", c, b_hs, exp_hs_def(c, 0));
            end
            n_checks++;
            if (a_vs !== 1'b1 || b_vs !== 1'b1) begin
                n_fail++;
                $display("FAIL vsync_idle cyc=%0d got=%0b/%0b exp=1/1", c, a_vs, b_vs);
            end
            if (c < 800 && a_hs === 1'b0) begin
                lows++;
                if (first < 0) first = c;
            end
            tick();
        end
        n_checks++;
        if (lows !== 96 || first !== 657) begin
            n_fail++;
            $display("FAIL hsync_width got=%0d first=%0d exp=96 first=657", lows, first);
        end
    endtask

    task automatic test_small_frames();
        int ticks = 0, t0 = -1, t1 = -1, vlows = 0, vfirst = -1;
        int h, v;
        do_reset();
        for (int c = 0; c < 310; c++) begin
            h = c % ST_H;
            v = (c / ST_H) % ST_V;
            n_checks++;
            if (int'(s1_px) !== h || int'(s1_py) !== v) begin
                n_fail++;
                $display("FAIL sm_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, s1_px, s1_py, h, v);
            end
            n_checks++;
            if (s1_vo !== (h < 8 && v < 6) || s1_ft !== (h == 0 && v == 6)) begin
                n_fail++;
                $display("FAIL sm_vo_ft cyc=%0d got=%0b/%0b exp=%0b/%0b", c, s1_vo, s1_ft,
                         (h < 8 && v < 6), (h == 0 && v == 6));
            end
            n_checks++;
            if (s1_hs !== exp_hs_sm(c, 1) || s0_hs !== exp_hs_sm(c, 0) || s3_hs !== exp_hs_sm(c, 3)) begin
                n_fail++;
                $display("FAIL sm_hsync cyc=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, s1_hs, s0_hs, s3_hs,
                         exp_hs_sm(c, 1), exp_hs_sm(c, 0), exp_hs_sm(c, 3));
            end
            n_checks++;
            if (s1_vs !== exp_vs_sm(c, 1) || s0_vs !== exp_vs_sm(c, 0) || s3_vs !== exp_vs_sm(c, 3)) begin
                n_fail++;
                $display("FAIL sm_vsync cyc=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, s1_vs, s0_vs, s3_vs,
                         exp_vs_sm(c, 1), exp_vs_sm(c, 0), exp_vs_sm(c, 3));
            end
            if (s1_ft === 1'b1) begin
                ticks++;
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
            if (c < 150 && s1_vs === 1'b0) begin
                vlows++;
                if (vfirst < 0) vfirst = c;
            end
            tick();
        end
        n_checks++;
        if (ticks !== 2 || t0 !== 90 || (t1 - t0) !== 150) begin
            n_fail++;
            $display("FAIL frame_tick got=%0d at %0d,%0d exp=2 at 90,240", ticks, t0, t1);
        end
        n_checks++;
        if (vlows !== 30 || vfirst !== 106) begin
            n_fail++;
            $display("FAIL vsync_width got=%0d first=%0d exp=30 first=106", vlows, vfirst);
        end
    endtask

    task automatic test_reset_mid_sync();
        do_reset();
        repeat (116) tick();
        n_checks++;
        if (s1_px !== 10'd11 || s1_py !== 10'd7) begin
            n_fail++;
            $display("FAIL mid_pos got=%0d/%0d exp=11/7", s1_px, s1_py);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (s1_vo !== 1'b0 || a_vo !== 1'b0 || s0_hs !== 1'b1 || s0_vs !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_reset got=vo%0b%0b hs%0b vs%0b exp=vo00 hs1 vs1",
                     s1_vo, a_vo, s0_hs, s0_vs);
        end
        tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c <= 20; c++) begin
            n_checks++;
            if (int'(s1_px) !== c % ST_H || int'(s1_py) !== c / ST_H) begin
                n_fail++;
                $display("FAIL mid_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", c, s1_px, s1_py,
                         c % ST_H, c / ST_H);
            end
            n_checks++;
            if (s1_hs !== exp_hs_sm(c, 1) || s0_hs !== exp_hs_sm(c, 0) || s3_hs !== exp_hs_sm(c, 3)) begin
                n_fail++;
                $display("FAIL mid_hsync cyc=%0d got=%0b%0b%0b exp=%0b%0b%0b", c, s1_hs, s0_hs, s3_hs,
                         exp_hs_sm(c, 1), exp_hs_sm(c, 0), exp_hs_sm(c, 3));
            end
            n_checks++;
            if (s1_vs !== 1'b1 || s0_vs !== 1'b1 || s3_vs !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_vsync cyc=%0d got=%0b%0b%0b exp=111", c, s1_vs, s0_vs, s3_vs);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hsync_default();
        test_small_frames();
        test_reset_mid_sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
